traffic_phase_arbiter: RTL

TRAFFIC_PHASE_ARBITER -- requirements
Module: traffic_phase_arbiter

---
 rtl/traffic_phase_arbiter_if.sv | 33 +++
 rtl/traffic_phase_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_arbiter_if.sv
// rtl/traffic_phase_arbiter_if.sv - control/status bundle for traffic_phase_arbiter (emerg_req only with EMERG_PREEMPT_EN)
interface traffic_phase_arbiter_if;
    logic       enable;
    logic [3:0] car_req;
    logic [7:0] green_duration;
    logic [7:0] yellow_duration;
    logic [7:0] red_holding;
`ifdef EMERG_PREEMPT_EN
    logic [3:0] emerg_req;
`endif
    logic [1:0] active_direction;
    logic [1:0] phase;
    logic [7:0] countdown_sec;
    logic [3:0] lamp_red;
    logic [3:0] lamp_yel;
    logic [3:0] lamp_grn;

    modport master (
        output enable, car_req, green_duration, yellow_duration, red_holding,
`ifdef EMERG_PREEMPT_EN
        output emerg_req,
`endif
        input  active_direction, phase, countdown_sec, lamp_red, lamp_yel, lamp_grn
    );

    modport slave (
        input  enable, car_req, green_duration, yellow_duration, red_holding,
`ifdef EMERG_PREEMPT_EN
        input  emerg_req,
`endif
        output active_direction, phase, countdown_sec, lamp_red, lamp_yel, lamp_grn
    );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// rtl/traffic_phase_arbiter.sv - 4-way round-robin traffic phase arbiter; EMERG_PREEMPT_EN adds emergency preemption
module traffic_phase_arbiter #(
    parameter int TICK_DIV = 100000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    traffic_phase_arbiter_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] PH_ALL_RED = 2'd0;
    localparam logic [1:0] PH_GREEN   = 2'd1;
    localparam logic [1:0] PH_YELLOW  = 2'd2;

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, CLEAR} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    cnt, cnt_n;
    logic [1:0]    dir, dir_n;
    logic [3:0]    pending, pending_n;
    logic [1:0]    phase_q, phase_n;
    logic [3:0]    red_q, yel_q, grn_q;
    logic [3:0]    red_n, yel_n, grn_n;
    logic          enter_green;
    logic          rr_found;
    logic [1:0]    rr_dir, rr_idx;
    logic          run, arb_ok, preempt, restart;
    logic [1:0]    arb_dir;
    logic [3:0]    dir_mask;
    logic [7:0]    g_len, y_len, r_len;

    function automatic logic [7:0] at_least_one(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

    assign g_len    = at_least_one(bus.green_duration);
    assign y_len    = at_least_one(bus.yellow_duration);
    assign r_len    = at_least_one(bus.red_holding);
    assign dir_mask = 4'b0001 << dir;
    assign tick     = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    // Searched from offset 4 down to 1 so the nearest pending direction after dir wins.
    always_comb begin
        rr_found = 1'b0;
        rr_dir   = dir;
        rr_idx   = dir;
        for (int i = 4; i >= 1; i--) begin
            rr_idx = dir + 2'(i);
            if (pending[rr_idx]) begin
                rr_found = 1'b1;
                rr_dir   = rr_idx;
            end
        end
    end

`ifdef EMERG_PREEMPT_EN
    logic       emerg_any;
    logic [1:0] emerg_dir;

    always_comb begin
        emerg_any = |bus.emerg_req;
        emerg_dir = 2'd0;
        if      (bus.emerg_req[0]) emerg_dir = 2'd0;
        else if (bus.emerg_req[1]) emerg_dir = 2'd1;
        else if (bus.emerg_req[2]) emerg_dir = 2'd2;
        else if (bus.emerg_req[3]) emerg_dir = 2'd3;
    end

    assign run     = bus.enable | emerg_any;
    assign arb_ok  = run && (emerg_any || rr_found);
    assign arb_dir = emerg_any ? emerg_dir : rr_dir;
    assign preempt = emerg_any && (dir != emerg_dir);
    // When no preempt is active, an asserted emergency is on dir itself.
    assign restart = emerg_any || (((pending & ~dir_mask) == 4'b0000) && bus.car_req[dir]);
`else
    assign run     = bus.enable;
    assign arb_ok  = run && rr_found;
    assign arb_dir = rr_dir;
    assign preempt = 1'b0;
    assign restart = ((pending & ~dir_mask) == 4'b0000) && bus.car_req[dir];
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        dir_n       = dir;
        enter_green = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = 8'd0;
                if (arb_ok) begin
                    state_n     = GREEN;
                    dir_n       = arb_dir;
                    cnt_n       = g_len;
                    enter_green = 1'b1;
                end
            end
            GREEN: begin
                if (preempt || !run) begin
                    state_n = YELLOW;
                    cnt_n   = y_len;
                end else if (tick) begin
                    if (cnt > 8'd1) begin
                        cnt_n = cnt - 8'd1;
                    end else if (restart) begin
                        cnt_n       = g_len;
                        enter_green = 1'b1;
                    end else begin
                        state_n = YELLOW;
                        cnt_n   = y_len;
                    end
                end
            end
            YELLOW: begin
                if (tick) begin
                    if (cnt > 8'd1) begin
                        cnt_n = cnt - 8'd1;
                    end else begin
                        state_n = CLEAR;
                        cnt_n   = r_len;
                    end
                end
            end
            CLEAR: begin
                if (tick) begin
                    if (cnt > 8'd1) begin
                        cnt_n = cnt - 8'd1;
                    end else if (arb_ok) begin
                        // Arbitrate here so a waiting request skips the extra IDLE cycle.
                        state_n     = GREEN;
                        dir_n       = arb_dir;
                        cnt_n       = g_len;
                        enter_green = 1'b1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 8'd0;
                    end
                end
            end
        endcase

        pending_n = (pending | bus.car_req) & ~(enter_green ? (4'b0001 << dir_n) : 4'b0000);
        grn_n     = (state_n == GREEN)  ? (4'b0001 << dir_n) : 4'b0000;
        yel_n     = (state_n == YELLOW) ? (4'b0001 << dir_n) : 4'b0000;
        red_n     = ~(grn_n | yel_n);
        phase_n   = (state_n == GREEN)  ? PH_GREEN :
                    (state_n == YELLOW) ? PH_YELLOW : PH_ALL_RED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            dir     <= 2'd3;
            pending <= 4'b0000;
            phase_q <= PH_ALL_RED;
            red_q   <= 4'hF;
            yel_q   <= 4'h0;
            grn_q   <= 4'h0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            dir     <= dir_n;
            pending <= pending_n;
            phase_q <= phase_n;
            red_q   <= red_n;
            yel_q   <= yel_n;
            grn_q   <= grn_n;
        end
    end

    assign bus.active_direction = dir;
    assign bus.phase            = phase_q;
    assign bus.countdown_sec    = cnt;
    assign bus.lamp_red         = red_q;
    assign bus.lamp_yel         = yel_q;
    assign bus.lamp_grn         = grn_q;

endmodule
